// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin scheduler sharing one pipelined FP multiplier among N_REQ requesters.
// Optional accepted-operation counter port op_count is present when FPMUL_ARB_PERF_EN is defined.

// Handshake (operand and result ports): a transfer happens on a rising clk edge where both
// valid and ready are high; ready may depend on valid, valid must never depend on ready.
module fpmul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*32-1:0]         req_a,
  input  logic [N_REQ*32-1:0]         req_b,
  output logic [N_REQ-1:0]            res_valid,
  input  logic [N_REQ-1:0]            res_ready,
  output logic [N_REQ*32-1:0]         res_data,
  output logic [31:0]                 mul_a,
  output logic [31:0]                 mul_b,
  input  logic [31:0]                 mul_z,
  output logic                        busy,
`ifdef FPMUL_ARB_PERF_EN
  output logic [31:0]                 op_count,
`endif
  output logic [2*N_REQ-1:0]          dbg_slot_state,
  output logic [$clog2(N_REQ)-1:0]    dbg_rr_ptr
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_INFLIGHT = 2'd1,
    S_HOLD     = 2'd2
  } slot_state_t;

  slot_state_t        r_state  [N_REQ];
  logic [31:0]        r_res    [N_REQ];
  logic [MUL_LAT-1:0] r_tag_v;
  logic [IDW-1:0]     r_tag_id [MUL_LAT];
  logic [IDW-1:0]     r_rr_ptr;
  logic [31:0]        r_mul_a;
  logic [31:0]        r_mul_b;

  logic [N_REQ-1:0]   w_elig;
  logic [N_REQ-1:0]   w_cap;
  logic [N_REQ-1:0]   w_slot_busy;
  logic [N_REQ-1:0]   w_grant;
  logic               w_found;
  logic               w_any;
  logic [IDW-1:0]     w_gnt_idx;
  logic [IDW-1:0]     w_rr_next;
  int                 w_scan;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    assign w_elig[gi]               = req_valid[gi] && (r_state[gi] == S_IDLE);
    assign w_cap[gi]                = r_tag_v[MUL_LAT-1] && (r_tag_id[MUL_LAT-1] == IDW'(gi));
    assign w_slot_busy[gi]          = (r_state[gi] != S_IDLE);
    assign res_valid[gi]            = (r_state[gi] == S_HOLD);
    assign res_data[gi*32 +: 32]    = r_res[gi];
    assign dbg_slot_state[2*gi +: 2] = r_state[gi];
  end

  // First eligible index at or after rr_ptr, wrapping around.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_scan    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan = int'(r_rr_ptr) + k;
      if (w_scan >= N_REQ) w_scan = w_scan - N_REQ;
      if (!w_found && w_elig[w_scan]) begin
        w_found   = 1'b1;
        w_gnt_idx = IDW'(w_scan);
      end
    end
  end

  // No grant is offered while reset is held, so req_ready reads 0 during reset.
  assign w_any     = w_found && !rst;
  assign w_grant   = w_any ? (N_REQ'(1) << w_gnt_idx) : '0;
  assign w_rr_next = (w_gnt_idx == IDW'(N_REQ-1)) ? '0 : w_gnt_idx + IDW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_rr_ptr <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      for (int s = 0; s < MUL_LAT; s++) r_tag_id[s] <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_state[i] <= S_IDLE;
        r_res[i]   <= '0;
      end
    end else begin
      r_tag_v[0]  <= w_any;
      r_tag_id[0] <= w_gnt_idx;
      for (int s = 1; s < MUL_LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
      if (w_any) begin
        r_mul_a  <= req_a[w_gnt_idx*32 +: 32];
        r_mul_b  <= req_b[w_gnt_idx*32 +: 32];
        r_rr_ptr <= w_rr_next;
      end else begin
        r_mul_a <= '0;
        r_mul_b <= '0;
      end
      for (int i = 0; i < N_REQ; i++) begin
        case (r_state[i])
          S_IDLE:     if (w_grant[i]) r_state[i] <= S_INFLIGHT;
          S_INFLIGHT: if (w_cap[i]) begin
                        r_state[i] <= S_HOLD;
                        r_res[i]   <= mul_z;
                      end
          S_HOLD:     if (res_ready[i]) r_state[i] <= S_IDLE;
          default:    r_state[i] <= S_IDLE;
        endcase
      end
    end
  end

`ifdef FPMUL_ARB_PERF_EN
  logic [31:0] r_op_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_op_count <= '0;
    else if (w_any) r_op_count <= r_op_count + 32'd1;
  end
  assign op_count = r_op_count;
`endif

  assign req_ready  = w_grant;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign busy       = (|r_tag_v) || (|w_slot_busy);
  assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Testbench for fpmul_arbiter: behavioural FP multiplier stand-in, per-requester scoreboard
// queues, and one task per scenario.
module tb_fpmul_arbiter;
  localparam int N = 4;
  localparam int L = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    res_valid;
  logic [N-1:0]    res_ready;
  logic [N*32-1:0] res_data;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic [31:0]     mul_z;
  logic            busy;
  logic [2*N-1:0]  dbg_slot_state;
  logic [1:0]      dbg_rr_ptr;
`ifdef FPMUL_ARB_PERF_EN
  logic [31:0]     op_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q [N][$];

  always #5 clk = ~clk;

  fpmul_arbiter #(.N_REQ(N), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .busy(busy),
`ifdef FPMUL_ARB_PERF_EN
    .op_count(op_count),
`endif
    .dbg_slot_state(dbg_slot_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // Truncating single-precision multiply for normal operands; zero exponent gives signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    e = 8'($urandom_range(100, 150));
    m = 23'($urandom);
    return {s, e, m};
  endfunction

  // Multiplier stand-in: captures at edge T+1, mul_z holds the product by edge T+L.
  logic [31:0] p0, p1, p2;
  always @(posedge clk) begin
    p0 <= fp_mul(mul_a, mul_b);
    p1 <= p0;
    p2 <= p1;
  end
  assign mul_z = p2;

  // Scoreboard: handshakes are stable from negedge to the following posedge.
  logic [31:0] sb_exp;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i])
          exp_q[i].push_back(fp_mul(req_a[i*32 +: 32], req_b[i*32 +: 32]));
        if (res_valid[i] && res_ready[i]) begin
          tests_run++;
          if (exp_q[i].size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected_result[%0d]: got %h expected no result", i, res_data[i*32 +: 32]);
          end else begin
            sb_exp = exp_q[i].pop_front();
            if (res_data[i*32 +: 32] !== sb_exp) begin
              tests_failed++;
              $display("FAIL sb_result[%0d]: got %h expected %h", i, res_data[i*32 +: 32], sb_exp);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: sample the grant before the edge, then refresh operands of granted requesters.
  task automatic advance(output logic [N-1:0] g);
    @(negedge clk);
    g = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        req_a[i*32 +: 32] = rand_op();
        req_b[i*32 +: 32] = rand_op();
      end
    end
  endtask

  task automatic reset_pulse();
    req_valid = '0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    req_valid = '0;
    res_ready = '1;
    while (busy && k < 60) begin
      tick();
      k++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_idle: busy got %b expected 0 within 60 cycles", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    res_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = rand_op();
      req_b[i*32 +: 32] = rand_op();
    end
    repeat (2) tick();
    tests_run++;
    if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    tests_run++;
    if (res_valid !== 4'b0000) begin tests_failed++; $display("FAIL reset_res_valid: got %b expected 0000", res_valid); end
    tests_run++;
    if (res_data !== '0) begin tests_failed++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
    tests_run++;
    if (mul_a !== 32'd0 || mul_b !== 32'd0) begin tests_failed++; $display("FAIL reset_mul_ops: got %h/%h expected 0/0", mul_a, mul_b); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (dbg_rr_ptr !== 2'd0 || dbg_slot_state !== '0) begin tests_failed++; $display("FAIL reset_state: got rr %0d slots %h expected 0 0", dbg_rr_ptr, dbg_slot_state); end
`ifdef FPMUL_ARB_PERF_EN
    tests_run++;
    if (op_count !== 32'd0) begin tests_failed++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
`endif
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    res_ready = '0;
    req_a[31:0] = 32'h4000_0000;
    req_b[31:0] = 32'h4040_0000;
    req_valid = 4'b0001;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    tests_run++;
    if (mul_a !== 32'h4000_0000 || mul_b !== 32'h4040_0000) begin tests_failed++; $display("FAIL single_mul_ops: got %h/%h expected 40000000/40400000", mul_a, mul_b); end
    tick();
    tests_run++;
    if (mul_a !== 32'd0 || mul_b !== 32'd0) begin tests_failed++; $display("FAIL single_idle_ops: got %h/%h expected 0/0", mul_a, mul_b); end
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      tests_run++;
      if (res_valid !== 4'b0000) begin tests_failed++; $display("FAIL single_early_valid: T+%0d got %b expected 0000", c, res_valid); end
    end
    tick();
    tests_run++;
    if (res_valid !== 4'b0001) begin tests_failed++; $display("FAIL single_valid: got %b expected 0001", res_valid); end
    tests_run++;
    if (res_data[31:0] !== 32'h40C0_0000) begin tests_failed++; $display("FAIL single_product: got %h expected 40c00000", res_data[31:0]); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_hold: got %b expected 1", busy); end
    repeat (3) tick();
    tests_run++;
    if (res_valid !== 4'b0001 || res_data[31:0] !== 32'h40C0_0000) begin tests_failed++; $display("FAIL single_hold: got %b %h expected 0001 40c00000", res_valid, res_data[31:0]); end
    res_ready = 4'b0001;
    tick();
    res_ready = '0;
    tests_run++;
    if (res_valid !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_consume: got valid %b busy %b expected 0000 0", res_valid, busy); end
  endtask

  task automatic test_all_four();
    logic [N-1:0] g;
    logic [N-1:0] exp_rv;
    reset_pulse();
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = rand_op();
      req_b[i*32 +: 32] = rand_op();
    end
    res_ready = '1;
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      advance(g);
      req_valid = req_valid & ~g;
      if (c < 4) begin
        tests_run++;
        if (g !== 4'(1 << c)) begin tests_failed++; $display("FAIL all4_grant[%0d]: got %b expected %b", c, g, 4'(1 << c)); end
      end
      exp_rv = (c >= 4 && c < 8) ? 4'(1 << (c - 4)) : 4'b0000;
      tests_run++;
      if (res_valid !== exp_rv) begin tests_failed++; $display("FAIL all4_res_valid[%0d]: got %b expected %b", c, res_valid, exp_rv); end
    end
    tests_run++;
    if (dbg_rr_ptr !== 2'd0) begin tests_failed++; $display("FAIL all4_rr_ptr: got %0d expected 0", dbg_rr_ptr); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL all4_busy: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g;
    logic [31:0]  held;
    int           cnt [N];
    int           k;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    res_ready = 4'b1101;
    req_valid = '1;
    k = 0;
    while (!res_valid[1] && k < 30) begin
      advance(g);
      k++;
    end
    tests_run++;
    if (res_valid[1] !== 1'b1) begin tests_failed++; $display("FAIL bp_hold_reached: got %b expected 1", res_valid[1]); end
    held = res_data[63:32];
    for (int c = 0; c < 20; c++) begin
      advance(g);
      for (int i = 0; i < N; i++) if (g[i]) cnt[i]++;
      tests_run++;
      if (g[1] !== 1'b0) begin tests_failed++; $display("FAIL bp_no_grant1[%0d]: got %b expected 0", c, g[1]); end
      tests_run++;
      if (res_data[63:32] !== held || res_valid[1] !== 1'b1) begin tests_failed++; $display("FAIL bp_stable[%0d]: got %h/%b expected %h/1", c, res_data[63:32], res_valid[1], held); end
    end
    tests_run++;
    if (cnt[0] < 2 || cnt[2] < 2 || cnt[3] < 2) begin tests_failed++; $display("FAIL bp_others_served: got %0d/%0d/%0d expected each >= 2", cnt[0], cnt[2], cnt[3]); end
    req_valid = 4'b0010;
    res_ready = 4'b1111;
    advance(g);
    tests_run++;
    if (g !== 4'b0000) begin tests_failed++; $display("FAIL bp_consume_cycle: got %b expected 0000", g); end
    advance(g);
    tests_run++;
    if (g !== 4'b0010) begin tests_failed++; $display("FAIL bp_regrant1: got %b expected 0010", g); end
    wait_idle();
  endtask

  task automatic test_fairness();
    logic [N-1:0] g;
    logic [N-1:0] prev;
    int           n;
    prev = '0;
    n = 0;
    res_ready = '1;
    req_valid = 4'b0101;
    for (int c = 0; c < 30; c++) begin
      advance(g);
      if (g != 4'b0000) begin
        tests_run++;
        if ((g !== 4'b0001 && g !== 4'b0100) || g === prev) begin tests_failed++; $display("FAIL fair_alternate[%0d]: got %b after %b", n, g, prev); end
        prev = g;
        n++;
      end
    end
    tests_run++;
    if (n < 8) begin tests_failed++; $display("FAIL fair_count: got %0d grants expected >= 8", n); end
    wait_idle();
  endtask

  task automatic test_reset_midflight();
    logic [N-1:0] g;
    res_ready = '1;
    req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      advance(g);
      req_valid = req_valid & ~g;
      tests_run++;
      if (g == 4'b0000) begin tests_failed++; $display("FAIL mid_grant[%0d]: got %b expected a grant", c, g); end
    end
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    tests_run++;
    if (res_valid !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_now: got valid %b busy %b expected 0000 0", res_valid, busy); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests_run++;
      if (res_valid !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_after[%0d]: got valid %b busy %b expected 0000 0", c, res_valid, busy); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    logic [N-1:0] v;
    int           grants;
    reset_pulse();
    grants = 0;
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      res_ready = 4'($urandom_range(0, 15));
      v = req_valid;
      advance(g);
      if (g != 4'b0000) grants++;
      tests_run++;
      if (!$onehot0(g) || (g & ~v) != 4'b0000) begin tests_failed++; $display("FAIL rand_grant_legal[%0d]: got %b with valid %b", c, g, v); end
    end
    wait_idle();
`ifdef FPMUL_ARB_PERF_EN
    tests_run++;
    if (op_count !== 32'(grants)) begin tests_failed++; $display("FAIL rand_op_count: got %0d expected %0d", op_count, grants); end
`endif
  endtask

`ifdef FPMUL_ARB_PERF_EN
  task automatic test_perf();
    logic [N-1:0] g;
    int           n;
    int           guard;
    reset_pulse();
    n = 0;
    guard = 0;
    res_ready = '1;
    while (n < 37 && guard < 400) begin
      req_valid = '1;
      advance(g);
      req_valid = '0;
      if (g != 4'b0000) n++;
      guard++;
    end
    tests_run++;
    if (op_count !== 32'd37) begin tests_failed++; $display("FAIL perf_count: got %0d expected 37", op_count); end
    wait_idle();
    reset_pulse();
    tests_run++;
    if (op_count !== 32'd0) begin tests_failed++; $display("FAIL perf_reset: got %0d expected 0", op_count); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    res_ready = '0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_reset_midflight();
    test_random();
`ifdef FPMUL_ARB_PERF_EN
    test_perf();
`endif
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (exp_q[i].size() != 0) begin tests_failed++; $display("FAIL sb_leftover[%0d]: got %0d pending expected 0", i, exp_q[i].size()); end
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
